alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational ALU for the core's execute stage. It adds single-cycle registered integer ops, signed/unsigned compare flags on every result, and iterative multi-cycle multiply and unsigned divide/remainder. Operands arrive on a valid/ready input channel and results leave on a valid/ready output channel, so the stage can stall on a long op or on a busy consumer.

---
 rtl/alu_if.sv | 36 +++
 rtl/alu_seq.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_if
// Description : Operand and result handshake bundle for alu_seq.
//               The master side (the execute-stage producer/consumer) drives
//               in_valid, a, b, op and out_ready. The slave side (alu_seq)
//               drives in_ready, out_valid, result and the eq/lt/ltu/err flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             eq;
  logic             lt;
  logic             ltu;
  logic             err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, eq, lt, ltu, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, eq, lt, ltu, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked execute-stage ALU. Single-cycle integer ops are
//               registered straight into the result. MUL (shift-add), DIVU and
//               REMU (restoring) iterate once per cycle for WIDTH cycles.
//               eq/lt/ltu/err are captured with the operands at accept.
// Ports       : clk, rst (async, active high)
//               bus.in_valid/in_ready/a/b/op   - operand channel
//               bus.out_valid/out_ready/result - result channel
//               bus.eq/lt/ltu/err              - flags held with result
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_if.slave      bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_SUB  = 4'b0010;
  localparam logic [3:0] c_OP_AND  = 4'b0011;
  localparam logic [3:0] c_OP_OR   = 4'b0100;
  localparam logic [3:0] c_OP_SEQ  = 4'b0110;
  localparam logic [3:0] c_OP_SLL  = 4'b0111;
  localparam logic [3:0] c_OP_XOR  = 4'b1000;
  localparam logic [3:0] c_OP_SLT  = 4'b1001;
  localparam logic [3:0] c_OP_SLTU = 4'b1010;
  localparam logic [3:0] c_OP_SRL  = 4'b1011;
  localparam logic [3:0] c_OP_MUL  = 4'b1100;
  localparam logic [3:0] c_OP_SRA  = 4'b1101;
  localparam logic [3:0] c_OP_DIVU = 4'b1110;
  localparam logic [3:0] c_OP_REMU = 4'b1111;

  logic [1:0]       r_state;
  logic [SHW-1:0]   r_cnt;
  logic [3:0]       r_op;
  // Iteration registers, shared by both long ops:
  //   MUL : r_acc = partial product, r_opa = multiplicand (shifts left),
  //         r_opb = multiplier (shifts right)
  //   DIV : r_acc = partial remainder, r_opa = dividend shifting out while
  //         quotient bits shift in, r_opb = divisor
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic             r_eq, r_lt, r_ltu, r_err;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_eq, w_lt, w_ltu;
  logic             w_is_multi;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_single;
  logic             w_unsup;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_fits;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_final;

  assign w_in_ready = !rst && ((r_state == c_IDLE) || ((r_state == c_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_eq  = (bus.a == bus.b);
  assign w_lt  = ($signed(bus.a) < $signed(bus.b));
  assign w_ltu = (bus.a < bus.b);
  assign w_sh  = bus.b[SHW-1:0];

  assign w_is_multi = (bus.op == c_OP_MUL) || (bus.op == c_OP_DIVU) || (bus.op == c_OP_REMU);

  always_comb begin
    w_single = '0;
    w_unsup  = 1'b0;
    case (bus.op)
      c_OP_ADD:  w_single = bus.a + bus.b;
      c_OP_SUB:  w_single = bus.a - bus.b;
      c_OP_AND:  w_single = bus.a & bus.b;
      c_OP_OR:   w_single = bus.a | bus.b;
      c_OP_XOR:  w_single = bus.a ^ bus.b;
      c_OP_SLL:  w_single = bus.a << w_sh;
      c_OP_SRL:  w_single = bus.a >> w_sh;
      c_OP_SRA:  w_single = $signed(bus.a) >>> w_sh;
      c_OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, w_lt};
      c_OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, w_ltu};
      c_OP_SEQ:  w_single = {{(WIDTH-1){1'b0}}, w_eq};
      default:   w_unsup  = 1'b1;
    endcase
  end

  // One shift-add step.
  assign w_mul_acc = r_opb[0] ? (r_acc + r_opa) : r_acc;

  // One restoring-divide step. The partial remainder is always below the
  // divisor, so the shifted value fits WIDTH+1 bits and the restored result
  // fits WIDTH bits. A zero divisor always "fits", which naturally yields an
  // all-ones quotient and a remainder equal to the dividend.
  assign w_div_shift = {r_acc, r_opa[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opb};
  assign w_div_fits  = !w_div_trial[WIDTH];
  assign w_div_rem   = w_div_fits ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_div_quo   = {r_opa[WIDTH-2:0], w_div_fits};

  always_comb begin
    w_final = w_mul_acc;
    case (r_op)
      c_OP_DIVU: w_final = w_div_quo;
      c_OP_REMU: w_final = w_div_rem;
      default:   w_final = w_mul_acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_acc       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_BUSY: begin
          if (r_op == c_OP_MUL) begin
            r_acc <= w_mul_acc;
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end else begin
            r_acc <= w_div_rem;
            r_opa <= w_div_quo;
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_result    <= w_final;
            r_out_valid <= 1'b1;
            r_state     <= c_DONE;
          end
        end
        default: begin
          // IDLE and DONE share the accept path; in DONE an accept can only
          // happen when the consumer takes the current result this cycle.
          if (w_accept) begin
            r_eq  <= w_eq;
            r_lt  <= w_lt;
            r_ltu <= w_ltu;
            if (w_is_multi) begin
              r_op        <= bus.op;
              r_acc       <= '0;
              r_opa       <= bus.a;
              r_opb       <= bus.b;
              r_cnt       <= SHW'(WIDTH - 1);
              r_err       <= 1'b0;
              r_out_valid <= 1'b0;
              r_state     <= c_BUSY;
            end else begin
              r_result    <= w_single;
              r_err       <= w_unsup;
              r_out_valid <= 1'b1;
              r_state     <= c_DONE;
            end
          end else if ((r_state == c_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
  assign bus.ltu       = r_ltu;
  assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq. A reference model computes
//               each accepted op's result and flags from plain arithmetic and
//               queues it; a negedge monitor compares every valid output
//               against the queue head. Directed sequences pin literal values,
//               latencies, back-pressure hold, and reset abandonment; a
//               randomized phase exercises handshakes and all opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  alu_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef logic [W+3:0] exp_t;  // {result, eq, lt, ltu, err}

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t q[$];
  bit   accepted_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    logic [W-1:0] r;
    logic e, l, lu, er;
    int sh;
    e  = (a == b);
    l  = ($signed(a) < $signed(b));
    lu = (a < b);
    er = 1'b0;
    sh = int'(b % W);
    case (op)
      4'h1: r = a + b;
      4'h2: r = a - b;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h8: r = a ^ b;
      4'h7: r = a << sh;
      4'hB: r = a >> sh;
      4'hD: r = $signed(a) >>> sh;
      4'h9: r = W'(l);
      4'hA: r = W'(lu);
      4'h6: r = W'(e);
      4'hC: r = a * b;
      4'hE: r = (b == 0) ? {W{1'b1}} : a / b;
      4'hF: r = (b == 0) ? a : a % b;
      default: begin r = '0; er = 1'b1; end
    endcase
    return {r, e, l, lu, er};
  endfunction

  // Compare process: every cycle with a valid output is checked against the
  // oldest outstanding model entry; accepts are recorded after the check.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      accepted_last = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 64'(1), 64'(0));
        else chk("result_flags", 64'({bus.result, bus.eq, bus.lt, bus.ltu, bus.err}), 64'(q[0]));
        if (bus.out_ready && q.size() > 0) void'(q.pop_front());
      end
      accepted_last = bus.in_valid && bus.in_ready;
      if (accepted_last) q.push_back(model(bus.a, bus.b, bus.op));
    end
  end

  // Drive one op from an idle/draining state, then scramble the inputs to
  // prove operands were latched. Measures edges from accept to out_valid.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    bit busy_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.op = op; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom_range(0, 15));
    lat = 1;
    busy_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid || lat > 200) break;
      if (bus.in_ready) busy_ready = 1'b1;
      @(posedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, 64'(bus.result), 64'(exp_res));
    if (exp_lat > 1) chk({name, "_in_ready_busy"}, 64'(busy_ready), 64'(0));
  endtask

  logic [W-1:0] bb_a [3] = '{32'd3, 32'd10, 32'h0000_00F0};
  logic [W-1:0] bb_b [3] = '{32'd5, 32'd3,  32'h0000_00FF};
  logic [3:0]   bb_op[3] = '{4'h1, 4'h2, 4'h8};
  logic [W-1:0] bb_r [3] = '{32'd8, 32'd7, 32'h0000_000F};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, cyc, n_late, mode;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_result", 64'(bus.result), 64'(0));
    chk("reset_flags", 64'({bus.eq, bus.lt, bus.ltu, bus.err}), 64'(0));
    chk("reset_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'h1, 32'h0, 1);
    chk("add_wrap_flags", 64'({bus.eq, bus.lt, bus.ltu, bus.err}), 64'(4'b0100));
    run_op("sra", 32'h8000_0000, 32'h0000_0024, 4'hD, 32'hF800_0000, 1);
    run_op("srl", 32'h8000_0000, 32'h0000_0024, 4'hB, 32'h0800_0000, 1);
    run_op("mul", 32'h0001_0003, 32'h0002_0005, 4'hC, 32'h000B_000F, W + 1);
    run_op("divu", 32'd100, 32'd7, 4'hE, 32'd14, W + 1);
    run_op("remu", 32'd100, 32'd7, 4'hF, 32'd2, W + 1);
    run_op("divu_zero", 32'd5, 32'd0, 4'hE, 32'hFFFF_FFFF, W + 1);
    run_op("remu_zero", 32'd5, 32'd0, 4'hF, 32'd5, W + 1);

    // Back-to-back single-cycle ops, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.a = bb_a[i]; bus.b = bb_b[i]; bus.op = bb_op[i];
      end else begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      end
      if (i > 0) begin
        @(negedge clk);
        chk("b2b_out_valid", 64'(bus.out_valid), 64'(1));
        chk("b2b_result", 64'(bus.result), 64'(bb_r[i-1]));
      end
    end
    // Stall: XOR 0xF0^0xFF held with eq=0 lt=1 ltu=1 err=0.
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", 64'({bus.out_valid, bus.result, bus.eq, bus.lt, bus.ltu, bus.err}),
          64'({1'b1, 32'h0000_000F, 4'b0110}));
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.a = 32'd7; bus.b = 32'd7; bus.op = 4'h5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("unsupported_op", 64'({bus.out_valid, bus.result, bus.eq, bus.lt, bus.ltu, bus.err}),
        64'({1'b1, 32'h0, 4'b1001}));

    // Reset in the middle of a divide abandons it.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = 32'd1000; bus.b = 32'd3; bus.op = 4'hE;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mid_result", 64'(bus.result), 64'(0));
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    n_late = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.out_valid) n_late++;
    end
    chk("no_late_completion", 64'(n_late), 64'(0));
    run_op("add_after_rst", 32'd2, 32'd3, 4'h1, 32'd5, 1);

    // Randomized handshake traffic; the monitor checks every result.
    sent = 0;
    cyc  = 0;
    while (sent < 300 && cyc < 30000) begin
      @(posedge clk); #1;
      cyc++;
      if (accepted_last) sent++;
      if (!bus.in_valid || accepted_last) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.op = 4'($urandom_range(0, 15));
        mode = $urandom_range(0, 4);
        bus.a = $urandom;
        bus.b = $urandom;
        if (mode == 1) begin bus.a = W'($urandom_range(0, 15)); bus.b = W'($urandom_range(0, 15)); end
        if (mode == 2) bus.b = bus.a;
        if (mode == 3) bus.b = '0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_ops_sent", 64'(sent), 64'(300));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || bus.out_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
